// File: rtl/edge_evt_pkg.sv
// edge_evt_pkg: edge polarity constants, arbiter FSM states and the round-robin search function
package edge_evt_pkg;
  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;
  typedef enum logic {ST_IDLE, ST_OFFER} state_t;
  function automatic logic [3:0] rr_next(input logic [15:0] mask, input logic [3:0] ptr, input int n);
    logic [3:0] g;
    logic hit;
    int j;
    g = '0;
    hit = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      j = (int'(ptr) + k) % n;
      if (k <= n && !hit && mask[j]) begin
        g = 4'(j);
        hit = 1'b1;
      end
    end
    return g;
  endfunction
endpackage

// File: rtl/edge_capture_cell.sv
// edge_capture_cell: per-channel edge detector holding prev, pending event, edge type and sticky overflow
module edge_capture_cell
  import edge_evt_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in,
  input  logic rise_en,
  input  logic fall_en,
  input  logic grant,
  input  logic ovf_clr,
  output logic pend,
  output logic pend_rise,
  output logic ovf
);
  logic prev, rise, fall, edge_hit;
  always_comb begin
    rise = in & ~prev & rise_en;
    fall = ~in & prev & fall_en;
    edge_hit = rise | fall;
  end
  always_ff @(posedge clk) begin
    prev <= in;
    if (reset) begin
      pend <= 1'b0;
      pend_rise <= EDGE_FALL;
      ovf <= 1'b0;
    end else begin
      pend <= (!rise_en && !fall_en) ? 1'b0 : edge_hit ? 1'b1 : grant ? 1'b0 : pend;
      pend_rise <= edge_hit ? (rise ? EDGE_RISE : EDGE_FALL) : pend_rise;
      ovf <= (edge_hit & pend & ~grant) | (ovf & ~ovf_clr);
    end
  end
endmodule

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: N-channel edge collector serialised round-robin onto a valid/ready event stream
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int N = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    in,
  input  logic [N-1:0]    rise_en,
  input  logic [N-1:0]    fall_en,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [ID_W-1:0] evt_id,
  output logic            evt_rising,
  output logic [N-1:0]    ovf,
  input  logic [N-1:0]    ovf_clr,
  output logic            busy
);
  state_t state, state_nx;
  logic [N-1:0] pend, pend_rise, grant;
  logic [ID_W-1:0] rr_ptr, idx;
  logic [3:0] g_full;
  logic load;
  for (genvar i = 0; i < N; i++) begin : g_ch
    edge_capture_cell u_cell (
      .clk(clk), .reset(reset), .in(in[i]), .rise_en(rise_en[i]), .fall_en(fall_en[i]),
      .grant(grant[i]), .ovf_clr(ovf_clr[i]), .pend(pend[i]), .pend_rise(pend_rise[i]), .ovf(ovf[i])
    );
    assign grant[i] = load && (idx == ID_W'(i));
  end
  always_comb begin
    g_full = rr_next(16'(pend), 4'(rr_ptr), N);
    idx = g_full[ID_W-1:0];
    load = (|pend) && (state == ST_IDLE || evt_ready);
    state_nx = load ? ST_OFFER : (state == ST_OFFER && evt_ready) ? ST_IDLE : state;
    busy = (|pend) | evt_valid;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      evt_valid <= 1'b0;
      evt_id <= '0;
      evt_rising <= EDGE_FALL;
      rr_ptr <= ID_W'(N - 1);
    end else begin
      state <= state_nx;
      evt_valid <= state_nx == ST_OFFER;
      if (load) begin
        evt_id <= idx;
        evt_rising <= pend_rise[idx];
        rr_ptr <= idx;
      end
    end
  end
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed checks of capture, round-robin order, backpressure, overflow and reset
module tb_edge_event_arbiter;
  logic clk = 0, reset = 1, evt_ready = 0, evt_valid, evt_rising, busy;
  logic [3:0] in = 4'hF, rise_en = 4'hF, fall_en = 4'hF, ovf_clr = 0, ovf;
  logic [1:0] evt_id;
  int tests = 0, fails = 0;
  logic seen;
  always #5 clk = ~clk;
  edge_event_arbiter #(.N(4), .ID_W(2)) dut (
    .clk(clk), .reset(reset), .in(in), .rise_en(rise_en), .fall_en(fall_en),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id), .evt_rising(evt_rising),
    .ovf(ovf), .ovf_clr(ovf_clr), .busy(busy)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_valid", evt_valid, 0);
    chk("rst_id", evt_id, 0);
    chk("rst_rising", evt_rising, 0);
    chk("rst_busy", busy, 0);
    reset = 0;
    seen = 0;
    repeat (20) begin
      tick();
      seen |= evt_valid;
    end
    chk("t1_no_evt", seen, 0);
    chk("t1_ovf", ovf, 0);
    rise_en = 4'h1; fall_en = 4'h0; evt_ready = 1;
    tick();
    in = 4'h0;
    repeat (2) tick();
    in = 4'h1;
    tick();
    chk("t2_k_valid", evt_valid, 0);
    chk("t2_k_busy", busy, 1);
    tick();
    chk("t2_valid", evt_valid, 1);
    chk("t2_id", evt_id, 0);
    chk("t2_rising", evt_rising, 1);
    tick();
    chk("t2_drop", evt_valid, 0);
    chk("t2_idle", busy, 0);
    reset = 1; in = 4'h0; rise_en = 4'hF;
    repeat (2) tick();
    reset = 0;
    for (int b = 0; b < 2; b++) begin
      in = 4'hF;
      tick();
      for (int i = 0; i < 4; i++) begin
        tick();
        chk($sformatf("t3_valid_b%0d_%0d", b, i), evt_valid, 1);
        chk($sformatf("t3_id_b%0d_%0d", b, i), evt_id, i);
      end
      tick();
      chk($sformatf("t3_end_valid_b%0d", b), evt_valid, 0);
      chk($sformatf("t3_end_busy_b%0d", b), busy, 0);
      in = 4'h0;
      tick();
    end
    evt_ready = 0; fall_en = 4'hF;
    in = 4'b0010;
    tick();
    tick();
    chk("t4_offer_id", evt_id, 1);
    in = 4'b0110;
    repeat (2) tick();
    in = 4'b0010;
    tick();
    chk("t4_ovf", ovf, 4'b0100);
    chk("t4_held_id", evt_id, 1);
    chk("t4_held_valid", evt_valid, 1);
    chk("t4_held_rising", evt_rising, 1);
    evt_ready = 1;
    tick();
    chk("t4_next_valid", evt_valid, 1);
    chk("t4_next_id", evt_id, 2);
    chk("t4_next_rising", evt_rising, 0);
    tick();
    chk("t4_drain", evt_valid, 0);
    evt_ready = 0;
    in = 4'b0110;
    tick();
    tick();
    in = 4'b0010;
    tick();
    in = 4'b0110; ovf_clr = 4'b0100;
    tick();
    ovf_clr = 0;
    chk("t5_set_wins", ovf, 4'b0100);
    ovf_clr = 4'b0100;
    tick();
    ovf_clr = 0;
    chk("t5_clear", ovf, 0);
    in = 4'b1110;
    tick();
    chk("t6_pre_valid", evt_valid, 1);
    chk("t6_pre_busy", busy, 1);
    reset = 1;
    tick();
    chk("t6_rst_valid", evt_valid, 0);
    chk("t6_rst_busy", busy, 0);
    reset = 0; evt_ready = 1;
    seen = 0;
    repeat (10) begin
      tick();
      seen |= evt_valid;
    end
    chk("t6_no_ch3", seen, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
